countdown_timer: RTL and testbench

Seconds countdown stage of the microwave controller. Holds a four-digit BCD time (MM:SS, max 99:59) that is loaded from the keypad front-end. It decrements once per second while the magnetron is on and drives `timer_done` into the magnetron control block. It also consumes that block's `mag_on` output, so counting runs only while the oven is cooking.

---
 rtl/countdown_timer.sv | 121 ++++++++++++
 tb/tb_countdown_timer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Seconds countdown for the microwave controller: BCD MM:SS time that is loaded from the
// keypad, decremented once per second while the magnetron is on, and flagged when it reaches 00:00.
module countdown_timer #(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        clearn,
  input  logic        mag_on,
  output logic [3:0]  min_tens,
  output logic [3:0]  min_units,
  output logic [3:0]  sec_tens,
  output logic [3:0]  sec_units,
  output logic        timer_done,
  output logic        tick
);

  localparam int unsigned PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    r_mt, r_mu, r_st, r_su;
  logic [PW-1:0] r_presc;
  logic          r_tick;

  logic [3:0]    w_mt_nxt, w_mu_nxt, w_st_nxt, w_su_nxt;
  logic [3:0]    w_dmt, w_dmu, w_dst, w_dsu;
  logic [PW-1:0] w_presc_nxt;
  logic          w_tick_nxt;
  logic          w_zero;
  logic          w_load_ok;

  assign w_zero    = (r_mt == 4'd0) && (r_mu == 4'd0) && (r_st == 4'd0) && (r_su == 4'd0);
  assign w_load_ok = load && (data_in[15:12] <= 4'd9) && (data_in[11:8] <= 4'd9) &&
                     (data_in[7:4] <= 4'd5) && (data_in[3:0] <= 4'd9);

  // One-second BCD decrement with borrow chain; only used when the time is nonzero.
  always_comb begin
    w_dmt = r_mt;
    w_dmu = r_mu;
    w_dst = r_st;
    w_dsu = r_su;
    if (r_su != 4'd0) begin
      w_dsu = r_su - 4'd1;
    end else begin
      w_dsu = 4'd9;
      if (r_st != 4'd0) begin
        w_dst = r_st - 4'd1;
      end else begin
        w_dst = 4'd5;
        if (r_mu != 4'd0) begin
          w_dmu = r_mu - 4'd1;
        end else begin
          w_dmu = 4'd9;
          w_dmt = r_mt - 4'd1;
        end
      end
    end
  end

  // Next state: clear beats load beats count; an invalid load falls through to counting.
  always_comb begin
    w_mt_nxt    = r_mt;
    w_mu_nxt    = r_mu;
    w_st_nxt    = r_st;
    w_su_nxt    = r_su;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    if (!clearn) begin
      w_mt_nxt    = 4'd0;
      w_mu_nxt    = 4'd0;
      w_st_nxt    = 4'd0;
      w_su_nxt    = 4'd0;
      w_presc_nxt = '0;
    end else if (w_load_ok) begin
      w_mt_nxt    = data_in[15:12];
      w_mu_nxt    = data_in[11:8];
      w_st_nxt    = data_in[7:4];
      w_su_nxt    = data_in[3:0];
      w_presc_nxt = '0;
    end else if (mag_on && !w_zero) begin
      if (r_presc == LAST) begin
        w_mt_nxt    = w_dmt;
        w_mu_nxt    = w_dmu;
        w_st_nxt    = w_dst;
        w_su_nxt    = w_dsu;
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b1;
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mt    <= 4'd0;
      r_mu    <= 4'd0;
      r_st    <= 4'd0;
      r_su    <= 4'd0;
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_mt    <= w_mt_nxt;
      r_mu    <= w_mu_nxt;
      r_st    <= w_st_nxt;
      r_su    <= w_su_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign min_tens   = r_mt;
  assign min_units  = r_mu;
  assign sec_tens   = r_st;
  assign sec_units  = r_su;
  assign timer_done = w_zero;
  assign tick       = r_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-based reference model queues the expected
// outputs after every edge and a negedge monitor compares them against the DUT.
module tb_countdown_timer;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic        clearn = 1'b1;
  logic        mag_on = 1'b1;
  logic [3:0]  min_tens, min_units, sec_tens, sec_units;
  logic        timer_done, tick;

  countdown_timer #(.TICKS_PER_SEC(T)) dut (
    .clk(clk), .reset(reset), .load(load), .data_in(data_in), .clearn(clearn),
    .mag_on(mag_on), .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
    .sec_units(sec_units), .timer_done(timer_done), .tick(tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    logic        done;
    logic        tk;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model state: remaining whole seconds and elapsed cycles of the current second.
  int   m_secs  = 0;
  int   m_phase = 0;
  bit   m_tick  = 1'b0;

  function automatic logic [15:0] s2bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit bcd_ok(input logic [15:0] d);
    return (d[15:12] <= 4'd9) && (d[11:8] <= 4'd9) && (d[7:4] <= 4'd5) && (d[3:0] <= 4'd9);
  endfunction

  function automatic int bcd2s(input logic [15:0] d);
    return (int'(d[15:12]) * 10 + int'(d[11:8])) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  task automatic model_edge(input bit rs, input bit l, input logic [15:0] d, input bit c,
                            input bit m);
    m_tick = 1'b0;
    if (rs) begin
      m_secs  = 0;
      m_phase = 0;
    end else if (!c) begin
      m_secs  = 0;
      m_phase = 0;
    end else if (l && bcd_ok(d)) begin
      m_secs  = bcd2s(d);
      m_phase = 0;
    end else if (m && m_secs > 0) begin
      m_phase = m_phase + 1;
      if (m_phase == int'(T)) begin
        m_phase = 0;
        m_secs  = m_secs - 1;
        m_tick  = 1'b1;
      end
    end
  endtask

  // Drive one cycle of inputs just after the negedge, then queue the model result of the edge.
  task automatic step(input bit rs, input bit l, input logic [15:0] d, input bit c, input bit m);
    exp_t e;
    @(negedge clk);
    #1;
    reset   = rs;
    load    = l;
    data_in = d;
    clearn  = c;
    mag_on  = m;
    @(posedge clk);
    cyc = cyc + 1;
    model_edge(rs, l, d, c, m);
    e.t    = s2bcd(m_secs);
    e.done = (m_secs == 0);
    e.tk   = m_tick;
    e.cyc  = cyc;
    q.push_back(e);
  endtask

  task automatic run(input int n, input bit m);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b1, m);
  endtask

  // Monitor: async reset check on a reset rising edge, otherwise pop and compare once per cycle.
  bit rst_seen = 1'b0;
  always @(negedge clk or posedge reset) begin
    exp_t e;
    logic [15:0] act;
    if (reset && !rst_seen) begin
      rst_seen = 1'b1;
      #1;
      act = {min_tens, min_units, sec_tens, sec_units};
      n_tests++;
      if (act !== 16'h0000 || timer_done !== 1'b1 || tick !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset: time=%h done=%b tick=%b, expected time=0000 done=1 tick=0",
                 act, timer_done, tick);
      end
    end else begin
      if (!reset) rst_seen = 1'b0;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {min_tens, min_units, sec_tens, sec_units};
        n_tests++;
        if (act !== e.t || timer_done !== e.done || tick !== e.tk) begin
          n_fail++;
          $display("FAIL edge%0d: time=%h done=%b tick=%b, expected time=%h done=%b tick=%b",
                   e.cyc, act, timer_done, tick, e.t, e.done, e.tk);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    int r;
    bit rs, c, l, m;

    // Reset held with mag_on high: nothing may move.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Full countdown of 01:02 to zero, then idle at zero.
    step(1'b0, 1'b1, 16'h0102, 1'b1, 1'b1);
    run(248, 1'b1);
    run(10, 1'b1);

    // Pause and resume mid-second.
    step(1'b0, 1'b1, 16'h0005, 1'b1, 1'b0);
    run(2, 1'b1);
    run(10, 1'b0);
    run(6, 1'b1);

    // Invalid loads are ignored, phase continues.
    step(1'b0, 1'b1, 16'h0030, 1'b1, 1'b1);
    run(1, 1'b1);
    step(1'b0, 1'b1, 16'h0070, 1'b1, 1'b1);
    step(1'b0, 1'b1, 16'h00A0, 1'b1, 1'b1);
    run(6, 1'b1);

    // Clear beats load; load beats a decrement.
    step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
    run(3, 1'b1);
    step(1'b0, 1'b1, 16'h0003, 1'b1, 1'b1);
    run(3, 1'b1);
    step(1'b0, 1'b1, 16'h0010, 1'b1, 1'b1);
    run(5, 1'b1);

    // Loading 00:00 is accepted.
    step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);
    run(3, 1'b1);

    // Borrow across all digits, then async reset between edges.
    step(1'b0, 1'b1, 16'h1000, 1'b1, 1'b1);
    run(4, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    run(3, 1'b1);

    // Randomized traffic with short times so zero is reached often.
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 99));
      rs = (r < 2);
      c  = !(r >= 2 && r < 5);
      l  = (r >= 5 && r < 15);
      m  = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 3) == 0)
        d = 16'($urandom);
      else
        d = {4'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
      step(rs, l, d, c, m);
    end

    run(2, 1'b0);
    @(negedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
